// File: rtl/reg_arb_pkg.sv
// Shared constants and FSM encoding for the register-file write arbiter.
package reg_arb_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_3x8.sv
// 3-to-8 one-hot decoder with enable; output is all zeros when disabled.
module decoder_3x8
  import reg_arb_pkg::*;
(
  input  logic [2:0]          a,
  input  logic                en,
  output logic [NUM_REGS-1:0] y
);

  // One-hot select of register a, gated by en
  always_comb begin
    y = '0;
    if (en) y = NUM_REGS'(1) << a;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-source register-file write arbiter (ALU writeback = 0, load writeback = 1).
// A 1-bit round-robin pointer breaks ties, the accepted write is registered
// into a single output stage, and that stage freezes while wr_stall is high.
// Optional build macro: REG_WRITE_R0_ZERO_EN -- writes to register 0 are
// accepted but never presented to the register file.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W = reg_arb_pkg::DATA_W,
  parameter int REG_AW = reg_arb_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [REG_AW-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [REG_AW-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [7:0]        wr_sel,
  output logic              wr_src
);

  state_t            state;
  state_t            state_nxt;
  logic              rr_last;
  logic              can_accept;
  logic              grant_id;
  logic              accept;
  logic              skip_write;
  logic [REG_AW-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  // Grant selection and combinational handshake; readies held low in reset
  always_comb begin
    can_accept = rst_n && ((state == IDLE) || ((state == WRITE) && !wr_stall));
    if (req0_valid && req1_valid) grant_id = ~rr_last;
    else                          grant_id = req1_valid;
    accept     = can_accept && (req0_valid || req1_valid);
    req0_ready = accept && !grant_id;
    req1_ready = accept &&  grant_id;
    acc_addr   = grant_id ? req1_addr : req0_addr;
    acc_data   = grant_id ? req1_data : req0_data;
`ifdef REG_WRITE_R0_ZERO_EN
    skip_write = (acc_addr == '0);
`else
    skip_write = 1'b0;
`endif
  end

  // Next-state logic: a suppressed (register-0) accept leaves no write pending
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !skip_write) state_nxt = WRITE;
      end
      WRITE: begin
        if (wr_stall)                    state_nxt = HOLD;
        else if (accept && !skip_write)  state_nxt = WRITE;
        else                             state_nxt = IDLE;
      end
      HOLD: begin
        if (!wr_stall) state_nxt = WRITE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Round-robin pointer: remembers the last accepted requester (tie goes to 0 after reset)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_last <= 1'b1;
    else if (accept) rr_last <= grant_id;
  end

  // Output stage: load on accept, drop wr_en once the write lands, freeze while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src  <= 1'b0;
    end else if (accept) begin
      wr_en   <= !skip_write;
      wr_addr <= acc_addr;
      wr_data <= acc_data;
      wr_src  <= grant_id;
    end else if (!wr_stall) begin
      wr_en   <= 1'b0;
    end
  end

  decoder_3x8 u_dec (
    .a  (wr_addr),
    .en (wr_en),
    .y  (wr_sel)
  );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: reset, single write, contention,
// stall/hold, reset during hold and the register-0 build option.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        wr_stall;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  wr_sel;
  logic        wr_src;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_write_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wr_stall   (wr_stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_sel     (wr_sel),
    .wr_src     (wr_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, "_rdy0"}, {31'b0, req0_ready}, {31'b0, r0});
    chk({tag, "_rdy1"}, {31'b0, req1_ready}, {31'b0, r1});
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [2:0] addr,
                        input logic [15:0] data, input logic [7:0] sel, input logic src);
    chk({tag, "_en"},   {31'b0, wr_en},   {31'b0, en});
    chk({tag, "_addr"}, {29'b0, wr_addr}, {29'b0, addr});
    chk({tag, "_data"}, {16'b0, wr_data}, {16'b0, data});
    chk({tag, "_sel"},  {24'b0, wr_sel},  {24'b0, sel});
    chk({tag, "_src"},  {31'b0, wr_src},  {31'b0, src});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_addr  = 3'd0; req0_data = 16'h0;
    req1_addr  = 3'd0; req1_data = 16'h0;
    wr_stall   = 1'b0;
    #2;
    // Reset state, requests present but nothing accepted
    chk_rdy("reset", 1'b0, 1'b0);
    chk_wr("reset", 1'b0, 3'd0, 16'h0, 8'h00, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // Single request from req0
    req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 16'hBEEF;
    #1;
    chk_rdy("single_acc", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk_wr("single_wr", 1'b1, 3'd5, 16'hBEEF, 8'b0010_0000, 1'b0);
    chk_rdy("single_idle", 1'b0, 1'b0);
    tick();
    chk("single_done_en", {31'b0, wr_en}, 32'd0);

    // Contention from fresh reset: grants 0,1,0,1 with back-to-back writes
    do_reset();
    req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'h2222;
    #1;
    chk_rdy("rr_c1", 1'b1, 1'b0);
    tick();
    chk_rdy("rr_c2", 1'b0, 1'b1);
    chk_wr("rr_w1", 1'b1, 3'd1, 16'h1111, 8'b0000_0010, 1'b0);
    tick();
    chk_rdy("rr_c3", 1'b1, 1'b0);
    chk_wr("rr_w2", 1'b1, 3'd2, 16'h2222, 8'b0000_0100, 1'b1);
    tick();
    chk_rdy("rr_c4", 1'b0, 1'b1);
    chk_wr("rr_w3", 1'b1, 3'd1, 16'h1111, 8'b0000_0010, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk_wr("rr_w4", 1'b1, 3'd2, 16'h2222, 8'b0000_0100, 1'b1);
    tick();
    chk("rr_done_en", {31'b0, wr_en}, 32'd0);

    // Stall: accept addr 3, stall three cycles while req1 waits
    req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 16'h3333;
    #1;
    chk_rdy("st_acc", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0;
    wr_stall   = 1'b1;
    req1_valid = 1'b1; req1_addr = 3'd6; req1_data = 16'h6666;
    #1;
    chk_wr("st_s1", 1'b1, 3'd3, 16'h3333, 8'b0000_1000, 1'b0);
    chk_rdy("st_s1", 1'b0, 1'b0);
    tick();
    chk_wr("st_s2", 1'b1, 3'd3, 16'h3333, 8'b0000_1000, 1'b0);
    chk_rdy("st_s2", 1'b0, 1'b0);
    tick();
    chk_wr("st_s3", 1'b1, 3'd3, 16'h3333, 8'b0000_1000, 1'b0);
    chk_rdy("st_s3", 1'b0, 1'b0);
    tick();
    wr_stall = 1'b0;
    #1;
    chk_wr("st_fall", 1'b1, 3'd3, 16'h3333, 8'b0000_1000, 1'b0);
    chk_rdy("st_fall", 1'b0, 1'b0);
    tick();
    chk("st_after_en", {31'b0, wr_en}, 32'd0);
    chk_rdy("st_next_acc", 1'b0, 1'b1);
    tick();
    req1_valid = 1'b0;
    #1;
    chk_wr("st_next_wr", 1'b1, 3'd6, 16'h6666, 8'b0100_0000, 1'b1);
    tick();
    chk("st_idle_en", {31'b0, wr_en}, 32'd0);

    // Reset while holding a stalled write
    req0_valid = 1'b1; req0_addr = 3'd7; req0_data = 16'h7777;
    #1;
    chk_rdy("rh_acc", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0;
    wr_stall   = 1'b1;
    #1;
    chk_wr("rh_wr", 1'b1, 3'd7, 16'h7777, 8'b1000_0000, 1'b0);
    tick();
    chk("rh_hold_en", {31'b0, wr_en}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk_wr("rh_async", 1'b0, 3'd0, 16'h0, 8'h00, 1'b0);
    chk_rdy("rh_async", 1'b0, 1'b0);
    rst_n    = 1'b1;
    wr_stall = 1'b0;
    tick();
    chk("rh_post1_en", {31'b0, wr_en}, 32'd0);
    tick();
    chk("rh_post2_en", {31'b0, wr_en}, 32'd0);

    // Register 0 write from req1
    req1_valid = 1'b1; req1_addr = 3'd0; req1_data = 16'h1234;
    #1;
    chk_rdy("r0_acc", 1'b0, 1'b1);
    tick();
    req1_valid = 1'b0;
    #1;
`ifdef REG_WRITE_R0_ZERO_EN
    chk("r0_en",  {31'b0, wr_en},  32'd0);
    chk("r0_sel", {24'b0, wr_sel}, 32'd0);
`else
    chk_wr("r0_wr", 1'b1, 3'd0, 16'h1234, 8'b0000_0001, 1'b1);
`endif
    tick();
    chk("r0_done_en", {31'b0, wr_en}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
